// File: rtl/elbeth_mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and data load/store:
// arbitrate in IDLE, hold the request through ACCESS until ack or timeout, pulse done in RESP.
module elbeth_mem_port_arbiter #(
  parameter int unsigned STARVE_MAX  = 3,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bit_select,
  output logic        mem_req,
  output logic        mem_we,
  output logic        if_done,
  output logic [31:0] if_rdata,
  output logic        dm_done,
  output logic [31:0] dm_rdata,
  output logic        bus_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [8:0] TMO_LIM    = 9'(TIMEOUT_CYC);

  state_t     state;
  logic [3:0] starve_cnt;
  logic [7:0] tmo_cnt;
  logic       fetch_wins;
  logic       tmo_hit;

  // Data has priority unless fetch has already waited through STARVE_MAX data grants.
  assign fetch_wins = if_req && (!dm_req || starve_cnt == STARVE_LIM);
  assign tmo_hit    = (TMO_LIM != 9'd0) && (({1'b0, tmo_cnt} + 9'd1) == TMO_LIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_select <= 1'b1;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
      bus_err    <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      busy       <= 1'b0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            bit_select <= fetch_wins;
            mem_req    <= 1'b1;
            mem_we     <= !fetch_wins && dm_we;
            tmo_cnt    <= '0;
            busy       <= 1'b1;
            state      <= ACCESS;
            if (!fetch_wins && if_req) begin
              if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            if (bit_select) begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              dm_done <= 1'b1;
              if (!mem_we) dm_rdata <= mem_rdata;
            end
            bus_err <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
            if (tmo_hit) begin
              if (bit_select) begin
                if_done  <= 1'b1;
                if_rdata <= '0;
              end else begin
                dm_done  <= 1'b1;
                dm_rdata <= '0;
              end
              bus_err <= 1'b1;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              state   <= RESP;
            end
          end
        end
        RESP: begin
          // Requests are still high this cycle, so no arbitration until back in IDLE.
          if_done <= 1'b0;
          dm_done <= 1'b0;
          bus_err <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elbeth_mem_port_arbiter.sv
// Scoreboarded bench: requester/memory agents drive stimulus, a transaction-level model
// predicts grants and completions, and a monitor compares what the arbiter presents.
module tb_elbeth_mem_port_arbiter;

  localparam int STARVE_MAX  = 2;
  localparam int TIMEOUT_CYC = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        bit_select, mem_req, mem_we, if_done, dm_done, bus_err, busy;
  logic [31:0] if_rdata, dm_rdata;

  elbeth_mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .dm_req(dm_req), .dm_we(dm_we),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bit_select(bit_select), .mem_req(mem_req),
    .mem_we(mem_we), .if_done(if_done), .if_rdata(if_rdata), .dm_done(dm_done),
    .dm_rdata(dm_rdata), .bus_err(bus_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic fetch; logic we; } grant_t;
  typedef struct { logic fetch; logic err; logic [31:0] rdata; int len; } done_t;

  grant_t exp_g[$];
  done_t  exp_d[$];
  logic   grant_log[$];

  int n_chk = 0;
  int n_err = 0;

  // Agent controls, written only by the main sequence.
  bit          rnd_mode = 1'b0;
  bit          if_hold = 1'b0, dm_hold = 1'b0;
  int          if_kick = 0, dm_kick = 0;
  int          we_cfg = 0;
  int          fix_dly = 1;
  bit          fix_dat_en = 1'b0;
  logic [31:0] fix_dat_i = 32'h0, fix_dat_d = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic pick_we(input int cfg);
    if (cfg == 2) return 1'($urandom_range(1));
    return (cfg == 1);
  endfunction

  // Requesters: hold each request until its done, then drop it or re-request at once.
  initial begin : requesters
    int if_used = 0;
    int dm_used = 0;
    forever begin
      @(negedge clk);
      if (if_req && if_done) begin
        if_req = if_hold || (rnd_mode && $urandom_range(1) == 0);
      end else if (!if_req && (if_used != if_kick || (rnd_mode && $urandom_range(3) == 0))) begin
        if_req = 1'b1;
        if (if_used != if_kick) if_used++;
      end
      if (dm_req && dm_done) begin
        dm_req = dm_hold || (rnd_mode && $urandom_range(1) == 0);
        if (dm_req) dm_we = pick_we(we_cfg);
      end else if (!dm_req && (dm_used != dm_kick || (rnd_mode && $urandom_range(3) == 0))) begin
        dm_req = 1'b1;
        dm_we  = pick_we(we_cfg);
        if (dm_used != dm_kick) dm_used++;
      end
    end
  end

  // Memory: acks after a chosen number of ACCESS cycles; stray acks when idle must be ignored.
  initial begin : memory
    int cnt = 0;
    int dly = 1;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (cnt == 0)
          dly = (fix_dly != 0) ? fix_dly :
                (($urandom_range(9) == 0) ? 12 : int'($urandom_range(4, 1)));
        cnt++;
        mem_ack   = (cnt == dly);
        mem_rdata = (mem_ack && fix_dat_en) ? (bit_select ? fix_dat_i : fix_dat_d) : $urandom();
      end else begin
        cnt       = 0;
        mem_ack   = rnd_mode && ($urandom_range(7) == 0);
        mem_rdata = $urandom();
      end
    end
  end

  // Reference model: one transaction in flight; after completion the port is free two edges later.
  initial begin : model
    int          cyc = 0, free_at = 0, waited = 0, fetch_waits = 0;
    bit          flight = 1'b0;
    logic        cur_fetch = 1'b1, cur_we = 1'b0;
    logic [31:0] m_if = 32'h0, m_dm = 32'h0;
    done_t       d;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        flight = 1'b0; fetch_waits = 0; m_if = 32'h0; m_dm = 32'h0; free_at = 0; cyc = 0;
      end else begin
        cyc++;
        if (flight) begin
          waited++;
          if (mem_ack || waited == TIMEOUT_CYC) begin
            if (cur_fetch) m_if = mem_ack ? mem_rdata : 32'h0;
            else if (!mem_ack) m_dm = 32'h0;
            else if (!cur_we) m_dm = mem_rdata;
            d.fetch = cur_fetch;
            d.err   = !mem_ack;
            d.rdata = cur_fetch ? m_if : m_dm;
            d.len   = waited;
            exp_d.push_back(d);
            flight  = 1'b0;
            free_at = cyc + 2;
          end
        end else if (cyc >= free_at && (if_req || dm_req)) begin
          cur_fetch   = if_req && (!dm_req || fetch_waits >= STARVE_MAX);
          cur_we      = !cur_fetch && dm_we;
          fetch_waits = (!cur_fetch && if_req) ? fetch_waits + 1 : 0;
          exp_g.push_back('{cur_fetch, cur_we});
          flight = 1'b1;
          waited = 0;
        end
      end
    end
  end

  // Monitor: compares every grant and completion the arbiter presents against the model.
  initial begin : monitor
    bit     prev_req = 1'b0, prev_done = 1'b0;
    int     len = 0;
    logic   cur_sel = 1'b1;
    grant_t g;
    done_t  d;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0; prev_done = 1'b0; len = 0;
      end else begin
        if (mem_req && !prev_req) begin
          if (exp_g.size() == 0) fail_now("unexpected_grant");
          else begin
            g = exp_g.pop_front();
            check("grant_sel", 32'(bit_select), 32'(g.fetch));
            check("grant_we", 32'(mem_we), 32'(g.we));
          end
          grant_log.push_back(bit_select);
          cur_sel = bit_select;
        end
        if (mem_req) begin
          len++;
          check("sel_held", 32'(bit_select), 32'(cur_sel));
        end
        check("we_only_with_req", 32'(mem_we & ~mem_req), 32'd0);
        if (if_done || dm_done) begin
          if (exp_d.size() == 0) fail_now("unexpected_done");
          else begin
            d = exp_d.pop_front();
            check("done_port", 32'({if_done, dm_done}), 32'({d.fetch, ~d.fetch}));
            check("bus_err", 32'(bus_err), 32'(d.err));
            check("rdata", d.fetch ? if_rdata : dm_rdata, d.rdata);
            check("access_len", 32'(len), 32'(d.len));
            check("busy_at_done", 32'(busy), 32'd1);
          end
          len = 0;
        end else begin
          check("stray_err", 32'(bus_err), 32'd0);
        end
        if (prev_done) check("busy_after_done", 32'(busy), 32'd0);
        prev_req  = mem_req;
        prev_done = if_done || dm_done;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    repeat (3) step();
    while ((if_req || dm_req || busy) && n < 400) begin
      step();
      n++;
    end
    check("idle_reached", 32'(if_req || dm_req || busy), 32'd0);
  endtask

  task automatic wait_grants(input int cnt);
    int n = 0;
    while (grant_log.size() < cnt && n < 300) begin
      step();
      n++;
    end
    check("grants_seen", 32'(grant_log.size() >= cnt), 32'd1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [5:0] order;
    int         n;

    repeat (3) step();
    check("rst_bit_select", 32'(bit_select), 32'd1);
    check("rst_outputs", 32'({mem_req, mem_we, if_done, dm_done, bus_err, busy}), 32'd0);
    check("rst_rdata", if_rdata | dm_rdata, 32'h0);
    reset = 1'b0;

    // Fetch only, ack in the second ACCESS cycle.
    fix_dly = 2; fix_dat_en = 1'b1; fix_dat_i = 32'h24020005;
    step(); if_kick++;
    wait_idle();
    check("fetch_rdata", if_rdata, 32'h24020005);

    // Contention: data first, then fetch.
    grant_log.delete();
    fix_dly = 1; fix_dat_d = 32'h11111111; fix_dat_i = 32'h22222222;
    step(); if_kick++; dm_kick++;
    wait_idle();
    check("contend_order", 32'({grant_log[0], grant_log[1]}), 32'd1);
    check("contend_dm_rdata", dm_rdata, 32'h11111111);
    check("contend_if_rdata", if_rdata, 32'h22222222);

    // Starvation: both requesters re-request immediately.
    grant_log.delete();
    fix_dat_en = 1'b0; if_hold = 1'b1; dm_hold = 1'b1;
    step(); if_kick++; dm_kick++;
    wait_grants(6);
    if_hold = 1'b0; dm_hold = 1'b0;
    wait_idle();
    order = 6'h0;
    for (int i = 0; i < 6; i++) order = {order[4:0], grant_log[i]};
    check("starve_order", 32'(order), 32'(6'b001001));

    // Timeout on a load that never gets an ack.
    fix_dly = 50;
    step(); dm_kick++;
    wait_idle();
    check("timeout_dm_rdata", dm_rdata, 32'h0);

    // Load 0xCAFEF00D, then a write must leave it untouched.
    fix_dly = 1; fix_dat_en = 1'b1; fix_dat_d = 32'hCAFEF00D;
    step(); dm_kick++;
    wait_idle();
    we_cfg = 1;
    step(); dm_kick++;
    wait_idle();
    check("write_keeps_rdata", dm_rdata, 32'hCAFEF00D);
    we_cfg = 0;

    // Asynchronous reset in the second ACCESS cycle of a fetch.
    fix_dly = 50;
    step(); if_kick++;
    n = 0;
    while (!mem_req && n < 20) begin step(); n++; end
    check("rst_test_grant", 32'(mem_req), 32'd1);
    step();
    #1 reset = 1'b1;
    #1 check("async_rst_req", 32'({mem_req, mem_we, if_done, dm_done, bus_err, busy}), 32'd0);
    fix_dly = 1;
    step();
    reset = 1'b0;
    step();
    check("regrant_after_rst", 32'({mem_req, bit_select}), 32'b11);
    wait_idle();

    // Randomized traffic with stray acks and occasional timeouts.
    fix_dly = 0; fix_dat_en = 1'b0; we_cfg = 2; rnd_mode = 1'b1;
    repeat (3000) step();
    rnd_mode = 1'b0;
    wait_idle();
    repeat (2) step();
    check("scoreboard_drained", 32'(exp_g.size() + exp_d.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
